// File: rtl/laser_pulse_gen.sv
// Programmable laser trigger generator: arms the driver, then emits a counted or
// continuous train of fixed-width pulses, with graceful stop and immediate fault abort.
module laser_pulse_gen #(
    parameter int CNT_W      = 32,
    parameter int ARM_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             fault_in,
    input  logic             clear_fault,
    input  logic [CNT_W-1:0] pulse_width,
    input  logic [CNT_W-1:0] pulse_period,
    input  logic [CNT_W-1:0] pulse_count,
    output logic             laser_pulse,
    output logic             laser_ready,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic             cfg_error,
    output logic [CNT_W-1:0] pulses_sent
);

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_PULSE_HI, S_PULSE_LO, S_FAULT
    } state_t;

    localparam logic [CNT_W-1:0] ARM_LOAD = CNT_W'(ARM_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] width_q, width_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] sent_q, sent_d;
    logic             stop_pend_q, stop_pend_d;
    logic             cfg_err_q, cfg_err_d;
    logic             done_evt;

    logic             pulse_q, pulse_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             fault_q, fault_d;

    logic             cfg_ok;
    logic             count_reached;
    logic [CNT_W-1:0] sent_inc;

    assign cfg_ok        = (pulse_width != '0) && (pulse_period > pulse_width);
    assign count_reached = (count_q != '0) && (sent_q == count_q);
    assign sent_inc      = (sent_q == '1) ? sent_q : sent_q + ONE;

    // NOTE: all state, including the shadow config, is reset so no X can reach the laser driver.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            width_q     <= '0;
            period_q    <= '0;
            count_q     <= '0;
            sent_q      <= '0;
            stop_pend_q <= 1'b0;
            cfg_err_q   <= 1'b0;
            pulse_q     <= 1'b0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            width_q     <= width_d;
            period_q    <= period_d;
            count_q     <= count_d;
            sent_q      <= sent_d;
            stop_pend_q <= stop_pend_d;
            cfg_err_q   <= cfg_err_d;
            pulse_q     <= pulse_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fault_q     <= fault_d;
        end
    end

    // NOTE: every comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        width_d     = width_q;
        period_d    = period_q;
        count_d     = count_q;
        sent_d      = sent_q;
        stop_pend_d = stop_pend_q;
        cfg_err_d   = cfg_err_q;
        done_evt    = 1'b0;

        if (fault_in && state_q != S_FAULT) begin
            state_d     = S_FAULT;
            stop_pend_d = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (cfg_ok) begin
                            width_d     = pulse_width;
                            period_d    = pulse_period;
                            count_d     = pulse_count;
                            sent_d      = '0;
                            cfg_err_d   = 1'b0;
                            stop_pend_d = 1'b0;
                            cnt_d       = ARM_LOAD;
                            state_d     = S_ARM;
                        end else begin
                            cfg_err_d = 1'b1;
                        end
                    end
                end
                S_ARM: begin
                    if (stop) begin
                        state_d     = S_IDLE;
                        done_evt    = 1'b1;
                        stop_pend_d = 1'b0;
                    end else if (cnt_q == '0) begin
                        state_d = S_PULSE_HI;
                        cnt_d   = width_q - ONE;
                        sent_d  = sent_inc;
                    end else begin
                        cnt_d = cnt_q - ONE;
                    end
                end
                S_PULSE_HI: begin
                    if (stop) stop_pend_d = 1'b1;
                    if (cnt_q == '0) begin
                        state_d = S_PULSE_LO;
                        cnt_d   = period_q - width_q - ONE;
                    end else begin
                        cnt_d = cnt_q - ONE;
                    end
                end
                S_PULSE_LO: begin
                    if (cnt_q == '0) begin
                        // A stop seen on the final LO cycle still ends the burst here.
                        if (stop_pend_q || stop || count_reached) begin
                            state_d     = S_IDLE;
                            done_evt    = 1'b1;
                            stop_pend_d = 1'b0;
                        end else begin
                            state_d = S_PULSE_HI;
                            cnt_d   = width_q - ONE;
                            sent_d  = sent_inc;
                        end
                    end else begin
                        cnt_d = cnt_q - ONE;
                        if (stop) stop_pend_d = 1'b1;
                    end
                end
                S_FAULT: begin
                    stop_pend_d = 1'b0;
                    if (clear_fault && !fault_in) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state and registered.
    always_comb begin
        pulse_d = (state_d == S_PULSE_HI);
        ready_d = (state_d == S_ARM) || (state_d == S_PULSE_HI) || (state_d == S_PULSE_LO);
        busy_d  = ready_d;
        fault_d = (state_d == S_FAULT);
        done_d  = done_evt;
    end

    assign laser_pulse = pulse_q;
    assign laser_ready = ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign fault       = fault_q;
    assign cfg_error   = cfg_err_q;
    assign pulses_sent = sent_q;

endmodule

// File: tb/tb_laser_pulse_gen.sv
// Self-checking bench for laser_pulse_gen: config table, timing-formula scoreboard for
// bursts, plus hand-written fault, stop, simultaneous-event and reset sequences.
module tb_laser_pulse_gen;
    localparam int CNT_W = 32;
    localparam int A     = 16;

    typedef struct packed {
        logic             pulse;
        logic             ready;
        logic             busy;
        logic             done;
        logic             fault;
        logic             cfg_err;
        logic [CNT_W-1:0] sent;
    } exp_t;

    typedef struct {
        logic [CNT_W-1:0] width;
        logic [CNT_W-1:0] period;
        logic             accept;
    } cfg_vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start, stop, fault_in, clear_fault;
    logic [CNT_W-1:0] pulse_width, pulse_period, pulse_count;
    logic             laser_pulse, laser_ready, busy, done, fault, cfg_error;
    logic [CNT_W-1:0] pulses_sent;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];

    laser_pulse_gen #(.CNT_W(CNT_W), .ARM_CYCLES(A)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .fault_in(fault_in),
        .clear_fault(clear_fault), .pulse_width(pulse_width), .pulse_period(pulse_period),
        .pulse_count(pulse_count), .laser_pulse(laser_pulse), .laser_ready(laser_ready),
        .busy(busy), .done(done), .fault(fault), .cfg_error(cfg_error),
        .pulses_sent(pulses_sent)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [CNT_W-1:0] act,
                         input logic [CNT_W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic p, input logic r, input logic b, input logic d,
                                input logic f, input logic e, input int s);
        exp_t x;
        x.pulse = p; x.ready = r; x.busy = b; x.done = d; x.fault = f; x.cfg_err = e;
        x.sent = CNT_W'(s);
        return x;
    endfunction

    // Expected outputs k cycles after an accepted start, from the timing rules alone.
    function automatic exp_t burst_exp(input int k, input int w, input int p, input int n);
        exp_t e;
        int   last;
        int   s;
        e    = '0;
        last = A + n * p;
        if (k >= 1 && k <= last) begin e.ready = 1'b1; e.busy = 1'b1; end
        if (k == last + 1) e.done = 1'b1;
        if (k > A && k <= last) e.pulse = ((k - A - 1) % p) < w;
        if (k > A) begin
            s = (k - A - 1) / p + 1;
            if (s > n) s = n;
            e.sent = CNT_W'(s);
        end
        return e;
    endfunction

    task automatic drive(input logic s, input logic sp, input logic f, input logic c);
        start = s; stop = sp; fault_in = f; clear_fault = c;
    endtask

    task automatic set_cfg(input int w, input int p, input int c);
        pulse_width = CNT_W'(w); pulse_period = CNT_W'(p); pulse_count = CNT_W'(c);
    endtask

    task automatic tick(input string name, input int k);
        exp_t e, a;
        @(posedge clk);
        #1;
        a = {laser_pulse, laser_ready, busy, done, fault, cfg_error, pulses_sent};
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL %s k=%0d: no expected entry queued", name, k);
        end else begin
            e = sb_q.pop_front();
            if (a !== e) begin
                failures++;
                $display("FAIL %s k=%0d: got p=%b r=%b b=%b d=%b f=%b e=%b s=%0d expected p=%b r=%b b=%b d=%b f=%b e=%b s=%0d",
                         name, k, a.pulse, a.ready, a.busy, a.done, a.fault, a.cfg_err, a.sent,
                         e.pulse, e.ready, e.busy, e.done, e.fault, e.cfg_err, e.sent);
            end
        end
    endtask

    task automatic step(input string name, input int k, input exp_t e);
        sb_q.push_back(e);
        tick(name, k);
    endtask

    // Start a burst and follow it for kmax cycles; config inputs are scrambled after
    // the start edge to show the shadow registers hold the running burst.
    task automatic run_burst(input string name, input int w, input int p, input int cnt,
                             input int n, input int kmax, input int stop_k);
        set_cfg(w, p, cnt);
        for (int k = 1; k <= kmax; k++) begin
            drive(k == 1, k == stop_k, 1'b0, 1'b0);
            if (k == 2) set_cfg(1, 3, 1);
            step(name, k, burst_exp(k, w, p, n));
        end
        drive(0, 0, 0, 0);
    endtask

    cfg_vec_t cfg_tbl[9];

    initial begin
        cfg_tbl[0] = '{CNT_W'(0), CNT_W'(5), 1'b0};
        cfg_tbl[1] = '{CNT_W'(5), CNT_W'(5), 1'b0};
        cfg_tbl[2] = '{CNT_W'(5), CNT_W'(6), 1'b1};
        cfg_tbl[3] = '{CNT_W'(5), CNT_W'(4), 1'b0};
        cfg_tbl[4] = '{CNT_W'(0), CNT_W'(0), 1'b0};
        cfg_tbl[5] = '{CNT_W'(1), CNT_W'(2), 1'b1};
        cfg_tbl[6] = '{CNT_W'(3), CNT_W'(2), 1'b0};
        cfg_tbl[7] = '{'1, '1, 1'b0};
        cfg_tbl[8] = '{CNT_W'(1), '1, 1'b1};

        rst = 1'b1;
        drive(0, 0, 0, 0);
        set_cfg(0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_pulse", CNT_W'(laser_pulse), '0);
        check("rst_ready", CNT_W'(laser_ready), '0);
        check("rst_busy", CNT_W'(busy), '0);
        check("rst_done", CNT_W'(done), '0);
        check("rst_fault", CNT_W'(fault), '0);
        check("rst_cfg_err", CNT_W'(cfg_error), '0);
        check("rst_sent", pulses_sent, '0);
        @(negedge clk);
        rst = 1'b0;

        // Config acceptance table; accepted starts are stopped in ARM (done, no pulse).
        for (int i = 0; i < 9; i++) begin
            logic acc;
            acc = cfg_tbl[i].accept;
            pulse_width = cfg_tbl[i].width; pulse_period = cfg_tbl[i].period;
            pulse_count = CNT_W'(1);
            drive(1, 0, 0, 0);
            step("cfg_start", i, mk(0, acc, acc, 0, 0, !acc, 0));
            if (acc) begin
                drive(0, 1, 0, 0);
                step("cfg_arm_stop", i, mk(0, 0, 0, 1, 0, 0, 0));
            end else begin
                drive(0, 0, 0, 0);
                step("cfg_hold", i, mk(0, 0, 0, 0, 0, 1, 0));
            end
            drive(0, 0, 0, 0);
            step("cfg_idle", i, mk(0, 0, 0, 0, 0, !acc, 0));
        end

        run_burst("counted", 4, 10, 3, 3, A + 3 * 10 + 3, -1);
        run_burst("graceful_stop", 6, 20, 0, 5, A + 100 + 3, A + 83);

        // Fault in the 3rd high cycle of the first pulse; start is ignored in FAULT.
        run_burst("fault_pre", 8, 16, 0, 1000, A + 3, -1);
        set_cfg(8, 16, 0);
        for (int k = A + 4; k <= A + 8; k++) begin
            drive(k >= A + 6, 0, 1, 0);
            step("fault_hold", k, mk(0, 0, 0, 0, 1, 0, 1));
        end
        drive(0, 0, 1, 1);
        step("fault_clear_blocked", A + 9, mk(0, 0, 0, 0, 1, 0, 1));
        drive(0, 0, 0, 1);
        step("fault_release", A + 10, mk(0, 0, 0, 0, 0, 0, 1));
        drive(0, 0, 0, 0);
        step("fault_idle", A + 11, mk(0, 0, 0, 0, 0, 0, 1));
        run_burst("fault_restart", 8, 16, 2, 2, A + 2 * 16 + 2, -1);

        // stop and fault_in together in a high phase.
        run_burst("stop_fault_pre", 4, 10, 0, 1000, A + 2, -1);
        drive(0, 1, 1, 0);
        step("stop_fault", A + 3, mk(0, 0, 0, 0, 1, 0, 1));
        drive(0, 0, 0, 1);
        step("stop_fault_release", A + 4, mk(0, 0, 0, 0, 0, 0, 1));
        drive(0, 0, 0, 0);
        step("stop_fault_idle", A + 5, mk(0, 0, 0, 0, 0, 0, 1));

        // fault_in on the edge where the count completes.
        run_burst("count_fault_pre", 4, 10, 2, 2, A + 20, -1);
        drive(0, 0, 1, 0);
        step("count_fault", A + 21, mk(0, 0, 0, 0, 1, 0, 2));
        drive(0, 0, 0, 1);
        step("count_fault_release", A + 22, mk(0, 0, 0, 0, 0, 0, 2));
        drive(0, 0, 0, 0);
        step("count_fault_idle", A + 23, mk(0, 0, 0, 0, 0, 0, 2));

        run_burst("min_cfg", 1, 2, 4, 4, A + 10, -1);

        // Asynchronous reset during the 2nd pulse of a minimum-config burst.
        run_burst("rst_pre", 1, 2, 4, 4, A + 3, -1);
        #2 rst = 1'b1;
        #1;
        check("midrst_pulse", CNT_W'(laser_pulse), '0);
        check("midrst_ready", CNT_W'(laser_ready), '0);
        check("midrst_busy", CNT_W'(busy), '0);
        check("midrst_sent", pulses_sent, '0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 0);
        step("post_rst_idle", 0, mk(0, 0, 0, 0, 0, 0, 0));
        run_burst("post_rst_burst", 2, 3, 1, 1, A + 5, -1);

        check("sb_drained", CNT_W'(sb_q.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
